// File: rtl/approx_mul_pipe.sv
// rtl/approx_mul_pipe.sv - three-stage quadrant-split approximate multiplier with valid/ready
// Optional error monitor: define APPROX_MUL_ERR_MON_EN to build the exact reference and err/err_max.
module approx_mul_pipe #(
    parameter int         WIDTH    = 8,
    parameter int         TRUNC    = 2,
    parameter logic [3:0] MODE_RST = 4'b0111
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [3:0]         mode,
    input  logic               mode_ovr,
    input  logic               mode_wr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] prod,
    output logic [2*WIDTH-1:0] err,
    output logic [2*WIDTH-1:0] err_max,
    input  logic               err_clr
);
    localparam int HALF = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);
    // Shifting by TRUNC==WIDTH yields 0, so the mask correctly becomes all zeros.
    localparam logic [WIDTH-1:0] QMASK = ~((ONE_Q << TRUNC) - ONE_Q);

    logic             stall;
    logic [3:0]       mode_dflt_q, mode_dflt_d;
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    logic [3:0]       m1_q, m1_d;
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] hh_q, hh_d, hl_q, hl_d, lh_q, lh_d, ll_q, ll_d;
    logic             v3_q, v3_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] qhh, qhl, qlh, qll;
    logic [WIDTH:0]   mid;
    logic [PW-1:0]    sum;
`ifdef APPROX_MUL_ERR_MON_EN
    logic [PW-1:0]    exact2_q, exact2_d;
    logic [PW-1:0]    err_q, err_d;
    logic [PW-1:0]    err_max_q, err_max_d;
`endif

    assign stall     = v3_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = v3_q;
    assign prod      = prod_q;
`ifdef APPROX_MUL_ERR_MON_EN
    assign err       = err_q;
    assign err_max   = err_max_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err            = '0;
    assign err_max        = '0;
`endif

    always_comb begin
        qhh = WIDTH'(a1_q[WIDTH-1:HALF]) * WIDTH'(b1_q[WIDTH-1:HALF]);
        qhl = WIDTH'(a1_q[WIDTH-1:HALF]) * WIDTH'(b1_q[HALF-1:0]);
        qlh = WIDTH'(a1_q[HALF-1:0])     * WIDTH'(b1_q[WIDTH-1:HALF]);
        qll = WIDTH'(a1_q[HALF-1:0])     * WIDTH'(b1_q[HALF-1:0]);
        mid = {1'b0, hl_q} + {1'b0, lh_q};
        sum = {hh_q, {WIDTH{1'b0}}} + (PW'(mid) << HALF) + PW'(ll_q);

        mode_dflt_d = mode_wr ? mode : mode_dflt_q;
        v1_d = v1_q; a1_d = a1_q; b1_d = b1_q; m1_d = m1_q;
        v2_d = v2_q; hh_d = hh_q; hl_d = hl_q; lh_d = lh_q; ll_d = ll_q;
        v3_d = v3_q; prod_d = prod_q;
`ifdef APPROX_MUL_ERR_MON_EN
        exact2_d  = exact2_q;
        err_d     = err_q;
        err_max_d = err_max_q;
`endif
        // Bubbles hold too while stalled, so the whole pipe advances as one.
        if (!stall) begin
            v1_d = in_valid;
            a1_d = a;
            b1_d = b;
            m1_d = mode_ovr ? mode : mode_dflt_q;
            v2_d = v1_q;
            hh_d = m1_q[3] ? (qhh & QMASK) : qhh;
            hl_d = m1_q[2] ? (qhl & QMASK) : qhl;
            lh_d = m1_q[1] ? (qlh & QMASK) : qlh;
            ll_d = m1_q[0] ? (qll & QMASK) : qll;
            v3_d   = v2_q;
            prod_d = sum;
`ifdef APPROX_MUL_ERR_MON_EN
            exact2_d = PW'(a1_q) * PW'(b1_q);
            err_d    = exact2_q - sum;
`endif
        end
`ifdef APPROX_MUL_ERR_MON_EN
        if (err_clr) begin
            err_max_d = (v3_q & out_ready) ? err_q : '0;
        end else if ((v3_q & out_ready) && (err_q > err_max_q)) begin
            err_max_d = err_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_dflt_q <= MODE_RST;
            v1_q <= 1'b0; a1_q <= '0; b1_q <= '0; m1_q <= '0;
            v2_q <= 1'b0; hh_q <= '0; hl_q <= '0; lh_q <= '0; ll_q <= '0;
            v3_q <= 1'b0; prod_q <= '0;
`ifdef APPROX_MUL_ERR_MON_EN
            exact2_q <= '0; err_q <= '0; err_max_q <= '0;
`endif
        end else begin
            mode_dflt_q <= mode_dflt_d;
            v1_q <= v1_d; a1_q <= a1_d; b1_q <= b1_d; m1_q <= m1_d;
            v2_q <= v2_d; hh_q <= hh_d; hl_q <= hl_d; lh_q <= lh_d; ll_q <= ll_d;
            v3_q <= v3_d; prod_q <= prod_d;
`ifdef APPROX_MUL_ERR_MON_EN
            exact2_q <= exact2_d; err_q <= err_d; err_max_q <= err_max_d;
`endif
        end
    end
endmodule

// File: tb/tb_approx_mul_pipe.sv
// tb/tb_approx_mul_pipe.sv - scoreboard bench for approx_mul_pipe (WIDTH=8, TRUNC=2)
module tb_approx_mul_pipe;
`ifdef APPROX_MUL_ERR_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] p;
        logic [15:0] e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, mode_ovr = 1'b0, mode_wr = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic [3:0]  mode = '0;
    logic        out_valid, out_ready = 1'b1, err_clr = 1'b0;
    logic [15:0] prod, err, err_max;

    exp_t        sb[$];
    exp_t        nxt, got;
    logic [3:0]  m_dflt = 4'b0111;
    logic [15:0] em = '0;
    logic [15:0] held;
    int          total = 0, bad = 0;

    approx_mul_pipe #(.WIDTH(8), .TRUNC(2), .MODE_RST(4'b0111)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .mode_ovr(mode_ovr), .mode_wr(mode_wr),
        .out_valid(out_valid), .out_ready(out_ready), .prod(prod), .err(err),
        .err_max(err_max), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, req);
        end
    endtask

    // Approximation drops the low two bits of each approximate sub-product at its weight.
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic [3:0] m);
        int ex, drop;
        exp_t r;
        ex   = int'(x) * int'(y);
        drop = 0;
        if (m[3]) drop += ((int'(x[7:4]) * int'(y[7:4])) % 4) * 256;
        if (m[2]) drop += ((int'(x[7:4]) * int'(y[3:0])) % 4) * 16;
        if (m[1]) drop += ((int'(x[3:0]) * int'(y[7:4])) % 4) * 16;
        if (m[0]) drop += ((int'(x[3:0]) * int'(y[3:0])) % 4);
        r.p = 16'(ex - drop);
        r.e = MON ? 16'(drop) : 16'h0;
        return r;
    endfunction

    function automatic logic [3:0] eff_mode();
        return mode_ovr ? mode : m_dflt;
    endfunction

    // One clock cycle: inputs are already set by the caller, nxt holds the beat's expectation.
    task automatic cyc();
        #1;
        check("err_max", err_max, em);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'(prod), 32'hDEAD_BEEF);
            end else begin
                got = sb.pop_front();
                check("prod", prod, got.p);
                check("err", err, got.e);
                if (MON) begin
                    if (err_clr || got.e > em) em = got.e;
                end
            end
        end else if (MON && err_clr) begin
            em = '0;
        end
        if (in_valid && in_ready) sb.push_back(nxt);
        if (mode_wr) m_dflt = mode;
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] x, input logic [7:0] y, input logic ovr,
                        input logic [3:0] m, input logic [15:0] p, input logic [15:0] e);
        in_valid = 1'b1; a = x; b = y; mode_ovr = ovr; mode = m;
        nxt.p = p; nxt.e = MON ? e : 16'h0;
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0; mode_wr = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cyc();
        cyc();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_prod", prod, 0);
        check("rst_err_max", err_max, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors plus latency of exactly three cycles.
        beat(8'hFF, 8'hFF, 1'b1, 4'b0000, 16'hFE01, 16'h0000);
        for (int k = 1; k <= 3; k++) begin
            check("latency", out_valid, (k == 3) ? 1 : 0);
            cyc();
        end
        beat(8'hFF, 8'hFF, 1'b0, 4'b0000, 16'hFDE0, 16'h0021);
        beat(8'h10, 8'h10, 1'b0, 4'b1111, 16'h0100, 16'h0000);
        beat(8'h10, 8'h10, 1'b1, 4'b1000, 16'h0000, 16'h0100);
        drain();
        check("err_max_hold", err_max, MON ? 32'h0100 : 32'h0);

        // err_clr coincident with a handshake loads that beat's err.
        beat(8'h03, 8'h03, 1'b1, 4'b0001, 16'h0008, 16'h0001);
        cyc(); cyc();
        check("clr_beat_valid", out_valid, 1);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("err_max_clr_hs", err_max, MON ? 32'h0001 : 32'h0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("err_max_clr", err_max, 0);

        // mode_wr coincident with acceptance: beat uses old default, next beat the new one.
        mode_wr = 1'b1;
        beat(8'hFF, 8'hFF, 1'b0, 4'b0000, 16'hFDE0, 16'h0021);
        mode_wr = 1'b0;
        beat(8'hFF, 8'hFF, 1'b0, 4'b1111, 16'hFE01, 16'h0000);
        drain();

        // Backpressure: A,B,C accepted, D refused while A waits.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
            end
            in_valid = 1'b1; mode_ovr = 1'b1;
            a = 8'(8'h31 + 8'(i * 37)); b = 8'(8'hC5 - 8'(i * 19)); mode = 4'(i);
            nxt = model(a, b, mode);
            cyc();
        end
        held = prod;
        for (int i = 0; i < 3; i++) cyc();
        check("stall_prod_stable", prod, held);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && in_valid; i++) begin
            #1;
            if (in_ready) begin
                cyc();
                in_valid = 1'b0;
            end else begin
                cyc();
            end
        end
        check("d_accepted", in_valid, 0);
        drain();

        // Random traffic with a reset pulse in the middle.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst_n = 1'b0;
                #2;
                check("midrst_out_valid", out_valid, 0);
                check("midrst_prod", prod, 0);
                check("midrst_err", err, 0);
                check("midrst_err_max", err_max, 0);
                sb.delete();
                em = '0;
                m_dflt = 4'b0111;
                in_valid = 1'b0;
                @(posedge clk); #3;
                rst_n = 1'b1;
                @(posedge clk); #1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            mode_wr   = ($urandom_range(0, 4) == 0);
            mode_ovr  = $urandom_range(0, 1) == 1;
            err_clr   = ($urandom_range(0, 19) == 0);
            a = 8'($urandom); b = 8'($urandom); mode = 4'($urandom);
            nxt = model(a, b, eff_mode());
            cyc();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end
endmodule
